alu_logic_pipe: RTL and testbench
=================================

Name: alu_logic_pipe

Overview:
- Parametrised, registered successor to the combinational 64-bit XOR unit used in the execute stage.
- Performs the Y86-64 OPq operation selected by `ifun` on two operands: ADD, SUB, AND or XOR.
- Output is held in a single-entry result register with a valid/ready handshake.
- Maintains the condition-code register (ZF, SF, OF) consumed by `cmovXX` and `jXX`.
- Sits between decode/operand fetch and the write-back/CC consumer.

Parameters:
- WIDTH, 64, operand and result width in bits (legal range 8..64).
- CNT_W, 16, width of the saturating accepted-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  global stall gate; when 0, no state changes (in_ready forced 0; output register, CC and counter hold).
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  unit can accept a bundle this cycle.
- ifun  input  4  0=ADD, 1=SUB, 2=AND, 3=XOR; any other value is illegal.
- valA  input  WIDTH  operand A.
- valB  input  WIDTH  operand B.
- set_cc  input  1  update CC when this bundle is accepted.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  downstream consumes the result this cycle.
- valE  output  WIDTH  registered result.
- cc  output  3  {ZF,SF,OF} condition-code register.
- err  output  1  sticky: an illegal ifun was accepted.
- op_count  output  CNT_W  number of accepted bundles, saturating.

Behaviour:
- Reset (asynchronous, any time, including mid-transaction) drives:
  - out_valid=0, valE=0, cc=3'b100 (ZF=1, SF=0, OF=0), err=0, op_count=0.
  - Any in-flight result is discarded.
- in_ready = enable & (!out_valid | out_ready). This is combinational; accept = in_valid & in_ready.
- Latency: 1 cycle. A bundle accepted at edge N appears on valE with out_valid=1 after edge N.
- Throughput: 1 bundle per cycle when out_ready is held 1 (simultaneous consume and accept in the same cycle is legal).
- Output register update:
  - On accept, load valE with the result and set out_valid=1.
  - Else, if out_valid & out_ready & enable, clear out_valid; valE holds its last value.
  - Else hold.
  - With enable=0, out_valid and valE hold even if out_ready=1.
- Arithmetic (all WIDTH bits, modular, carry discarded):
  - ADD: R = valB + valA.
  - SUB: R = valB - valA (Y86 order).
  - AND: R = valB & valA.
  - XOR: R = valB ^ valA.
- Flags, computed from R:
  - ZF = (R == 0).
  - SF = R[WIDTH-1].
  - OF for ADD: (a_s == b_s) & (r_s != a_s).
  - OF for SUB: (a_s != b_s) & (r_s != b_s).
  - OF for AND/XOR: 0.
  - Here a_s, b_s, r_s are the MSBs of valA, valB and R.
- CC loads only on accept with set_cc=1; otherwise it holds.
- Illegal ifun (4..15) on accept:
  - valE is loaded with 0 and out_valid=1, so the handshake still completes.
  - CC is not updated regardless of set_cc.
  - err is set to 1 and stays set until reset.
- op_count increments on every accept, including illegal ones, and saturates at 2^CNT_W-1 (no wrap).
- in_valid=1 with in_ready=0: upstream must hold the bundle stable. The unit samples nothing.
- Inputs are ignored whenever in_valid=0.

Test Plan:
- Reset: assert reset mid-stream with out_valid=1 -> asynchronously out_valid=0, valE=0, cc=100, err=0, op_count=0.
- XOR: A=1, B=2, ifun=3, set_cc=1, out_ready=1 -> next cycle valE=3, cc=000. Then A=3, B=4 -> valE=7. Then A=B=0xFFFF_FFFF_FFFF_FFFF -> valE=0, cc=100.
- Overflow:
  - ADD A=B=0x7FFF_FFFF_FFFF_FFFF -> valE=0xFFFF_FFFF_FFFF_FFFE, cc=011.
  - SUB A=1, B=0x8000_0000_0000_0000 -> valE=0x7FFF_FFFF_FFFF_FFFF, cc=001.
  - SUB A=5, B=5 -> valE=0, cc=100.
- Backpressure: hold out_ready=0 after one accept -> in_ready=0, the second bundle is held and valE is stable. Raise out_ready for one cycle -> the second result is loaded the same edge, with no loss or duplication. Then stream 4 back-to-back bundles with out_ready=1 -> 4 results on consecutive cycles, op_count=4.
- enable=0 with in_valid=1 and out_ready=1 -> no accept, out_valid/valE/cc/op_count frozen. Re-enable -> the bundle is accepted.
- Illegal op and counter, with CNT_W=2:
  - ifun=7, set_cc=1 -> valE=0, cc unchanged, err=1 and sticky.
  - 5 accepts -> op_count saturates at 3.
- WIDTH=8: ADD A=0x80, B=0x80 -> valE=0x00, cc=101.

Source files
------------

// File: rtl/alu_logic_pipe.sv
// alu_logic_pipe: registered Y86-64 OPq execute unit (ADD/SUB/AND/XOR) with
// a single-entry valid/ready result register, condition codes {ZF,SF,OF},
// a sticky illegal-function flag and a saturating accepted-bundle counter.
module alu_logic_pipe #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic             set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] valE,
    output logic [2:0]       cc,
    output logic             err,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [3:0]       IFUN_ADD = 4'd0;
    localparam logic [3:0]       IFUN_SUB = 4'd1;
    localparam logic [3:0]       IFUN_AND = 4'd2;
    localparam logic [3:0]       IFUN_XOR = 4'd3;
    localparam logic [2:0]       CC_RESET = 3'b100;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] vale_q, vale_d;
    logic [2:0]       cc_q, cc_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic [WIDTH-1:0] res_c;
    logic             of_c;
    logic             legal_c;
    logic             zf_c;
    logic             sf_c;
    logic             accept_c;

    // Accept whenever enabled and the result slot is empty or draining now.
    assign in_ready = enable & (~out_valid_q | out_ready);
    assign accept_c = in_valid & in_ready;

    // Operation datapath and flag generation; illegal ifun yields a zero result.
    always_comb begin
        res_c   = '0;
        of_c    = 1'b0;
        legal_c = 1'b1;
        case (ifun)
            IFUN_ADD: begin
                res_c = valB + valA;
                of_c  = (valA[WIDTH-1] == valB[WIDTH-1]) &&
                        (res_c[WIDTH-1] != valA[WIDTH-1]);
            end
            IFUN_SUB: begin
                res_c = valB - valA;
                of_c  = (valA[WIDTH-1] != valB[WIDTH-1]) &&
                        (res_c[WIDTH-1] != valB[WIDTH-1]);
            end
            IFUN_AND: res_c = valB & valA;
            IFUN_XOR: res_c = valB ^ valA;
            default:  legal_c = 1'b0;
        endcase
        zf_c = (res_c == '0);
        sf_c = res_c[WIDTH-1];
    end

    // Next-state for result slot, condition codes, error flag and counter.
    always_comb begin
        out_valid_d = out_valid_q;
        vale_d      = vale_q;
        cc_d        = cc_q;
        err_d       = err_q;
        op_count_d  = op_count_q;
        if (accept_c) begin
            out_valid_d = 1'b1;
            vale_d      = res_c;
            if (legal_c && set_cc) begin
                cc_d = {zf_c, sf_c, of_c};
            end
            if (!legal_c) begin
                err_d = 1'b1;
            end
            if (op_count_q != CNT_MAX) begin
                op_count_d = op_count_q + CNT_W'(1);
            end
        end else if (out_valid_q && out_ready && enable) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            vale_q      <= '0;
            cc_q        <= CC_RESET;
            err_q       <= 1'b0;
            op_count_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            vale_q      <= vale_d;
            cc_q        <= cc_d;
            err_q       <= err_d;
            op_count_q  <= op_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign valE      = vale_q;
    assign cc        = cc_q;
    assign err       = err_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_logic_pipe.sv
// Testbench for alu_logic_pipe: a 64-bit/16-bit-counter instance driven by
// directed and random stimulus against a reference model, plus an
// 8-bit/2-bit-counter instance for the narrow-width and saturation cases.
module tb_alu_logic_pipe;

    logic        clk = 1'b0;
    logic        reset, enable, in_valid, set_cc, out_ready;
    logic [3:0]  ifun;
    logic [63:0] valA, valB;
    logic        in_ready, out_valid, err;
    logic [63:0] valE;
    logic [2:0]  cc;
    logic [15:0] op_count;

    logic        s_reset, s_enable, s_in_valid, s_set_cc, s_out_ready;
    logic [3:0]  s_ifun;
    logic [7:0]  s_valA, s_valB;
    logic        s_in_ready, s_out_valid, s_err;
    logic [7:0]  s_valE;
    logic [2:0]  s_cc;
    logic [1:0]  s_op_count;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state
    bit          m_valid;
    logic [63:0] m_vale;
    logic [2:0]  m_cc;
    bit          m_err;
    int          m_cnt;

    always #5 clk = ~clk;

    alu_logic_pipe #(.WIDTH(64), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .in_ready(in_ready), .ifun(ifun), .valA(valA), .valB(valB),
        .set_cc(set_cc), .out_valid(out_valid), .out_ready(out_ready),
        .valE(valE), .cc(cc), .err(err), .op_count(op_count)
    );

    alu_logic_pipe #(.WIDTH(8), .CNT_W(2)) dut_s (
        .clk(clk), .reset(s_reset), .enable(s_enable), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .ifun(s_ifun), .valA(s_valA), .valB(s_valB),
        .set_cc(s_set_cc), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .valE(s_valE), .cc(s_cc), .err(s_err), .op_count(s_op_count)
    );

    // Y86 OPq semantics: overflow means the true signed result is not representable.
    function automatic void ref_op(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                                   output logic [63:0] r, output logic [2:0] fl, output bit legal);
        logic signed [64:0] sa, sb, exact;
        bit ovf;
        sa = 65'($signed(a));
        sb = 65'($signed(b));
        legal = 1'b1;
        ovf = 1'b0;
        r = '0;
        case (f)
            4'd0: begin exact = sb + sa; r = exact[63:0]; ovf = (exact != 65'($signed(r))); end
            4'd1: begin exact = sb - sa; r = exact[63:0]; ovf = (exact != 65'($signed(r))); end
            4'd2: r = b & a;
            4'd3: r = b ^ a;
            default: legal = 1'b0;
        endcase
        fl = {(r == 64'd0), r[63], ovf};
    endfunction

    // Advance one clock edge and the model with the inputs currently applied.
    task automatic tick();
        logic [63:0] r;
        logic [2:0]  fl;
        bit          legal, acc;
        acc = in_valid && enable && (!m_valid || out_ready);
        ref_op(ifun, valA, valB, r, fl, legal);
        @(posedge clk);
        if (acc) begin
            m_valid = 1'b1;
            m_vale  = r;
            if (legal && set_cc) m_cc = fl;
            if (!legal) m_err = 1'b1;
            if (m_cnt < 65535) m_cnt++;
        end else if (m_valid && out_ready && enable) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_vale = '0; m_cc = 3'b100; m_err = 1'b0; m_cnt = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; s_reset = 1'b1;
        enable = 1'b0; in_valid = 1'b0; ifun = 4'd0; valA = '0; valB = '0; set_cc = 1'b0; out_ready = 1'b0;
        s_enable = 1'b0; s_in_valid = 1'b0; s_ifun = 4'd0; s_valA = '0; s_valB = '0; s_set_cc = 1'b0; s_out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if (valE !== 64'd0) $display("FAIL reset_valE got %h exp 0", valE); else n_pass++;
        n_total++; if (cc !== 3'b100) $display("FAIL reset_cc got %b exp 100", cc); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else n_pass++;
        n_total++; if (op_count !== 16'd0) $display("FAIL reset_op_count got %0d exp 0", op_count); else n_pass++;
        reset = 1'b0; s_reset = 1'b0;
    endtask

    task automatic test_xor();
        enable = 1'b1; out_ready = 1'b1; in_valid = 1'b1; set_cc = 1'b1;
        ifun = 4'd3; valA = 64'd1; valB = 64'd2;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL xor_in_ready got %b exp 1", in_ready); else n_pass++;
        tick();
        n_total++; if (out_valid !== 1'b1) $display("FAIL xor1_out_valid got %b exp 1", out_valid); else n_pass++;
        n_total++; if (valE !== 64'd3) $display("FAIL xor1_valE got %h exp 3", valE); else n_pass++;
        n_total++; if (cc !== 3'b000) $display("FAIL xor1_cc got %b exp 000", cc); else n_pass++;
        valA = 64'd3; valB = 64'd4;
        tick();
        n_total++; if (valE !== 64'd7) $display("FAIL xor2_valE got %h exp 7", valE); else n_pass++;
        valA = '1; valB = '1;
        tick();
        n_total++; if (valE !== 64'd0) $display("FAIL xor3_valE got %h exp 0", valE); else n_pass++;
        n_total++; if (cc !== 3'b100) $display("FAIL xor3_cc got %b exp 100", cc); else n_pass++;
        in_valid = 1'b0;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL xor_drain_out_valid got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_overflow();
        in_valid = 1'b1; set_cc = 1'b1; out_ready = 1'b1;
        ifun = 4'd0; valA = 64'h7FFF_FFFF_FFFF_FFFF; valB = 64'h7FFF_FFFF_FFFF_FFFF;
        tick();
        n_total++; if (valE !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL add_ovf_valE got %h exp fffffffffffffffe", valE); else n_pass++;
        n_total++; if (cc !== 3'b011) $display("FAIL add_ovf_cc got %b exp 011", cc); else n_pass++;
        ifun = 4'd1; valA = 64'd1; valB = 64'h8000_0000_0000_0000;
        tick();
        n_total++; if (valE !== 64'h7FFF_FFFF_FFFF_FFFF) $display("FAIL sub_ovf_valE got %h exp 7fffffffffffffff", valE); else n_pass++;
        n_total++; if (cc !== 3'b001) $display("FAIL sub_ovf_cc got %b exp 001", cc); else n_pass++;
        valA = 64'd5; valB = 64'd5;
        tick();
        n_total++; if (valE !== 64'd0) $display("FAIL sub_zero_valE got %h exp 0", valE); else n_pass++;
        n_total++; if (cc !== 3'b100) $display("FAIL sub_zero_cc got %b exp 100", cc); else n_pass++;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; set_cc = 1'b0;
        ifun = 4'd3; valA = 64'h11; valB = 64'h22;
        tick();
        n_total++; if (valE !== 64'h33) $display("FAIL bp_first_valE got %h exp 33", valE); else n_pass++;
        ifun = 4'd0; valA = 64'h1; valB = 64'h40;
        #1;
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b exp 0", in_ready); else n_pass++;
        repeat (2) tick();
        n_total++; if (valE !== 64'h33 || out_valid !== 1'b1) $display("FAIL bp_hold valE %h valid %b exp 33 1", valE, out_valid); else n_pass++;
        out_ready = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready got %b exp 1", in_ready); else n_pass++;
        tick();
        n_total++; if (valE !== 64'h41 || out_valid !== 1'b1) $display("FAIL bp_second valE %h valid %b exp 41 1", valE, out_valid); else n_pass++;
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        n_total++; if (valE !== 64'h41 || out_valid !== 1'b1) $display("FAIL bp_no_dup valE %h valid %b exp 41 1", valE, out_valid); else n_pass++;
        out_ready = 1'b1;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL bp_drain got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        #1;
        enable = 1'b1; out_ready = 1'b1; in_valid = 1'b1; set_cc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ifun = 4'($urandom_range(0, 3));
            valA = {$urandom, $urandom}; valB = {$urandom, $urandom};
            tick();
            n_total++; if (out_valid !== 1'b1 || valE !== m_vale) $display("FAIL b2b_%0d valE %h valid %b exp %h 1", i, valE, out_valid, m_vale); else n_pass++;
        end
        n_total++; if (op_count !== 16'd4) $display("FAIL b2b_op_count got %0d exp 4", op_count); else n_pass++;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_enable();
        in_valid = 1'b1; out_ready = 1'b0; set_cc = 1'b1; ifun = 4'd3; valA = 64'hF0; valB = 64'h0F;
        tick();
        enable = 1'b0; out_ready = 1'b1; ifun = 4'd0; valA = 64'd2; valB = 64'd3;
        #1;
        n_total++; if (in_ready !== 1'b0) $display("FAIL en_in_ready got %b exp 0", in_ready); else n_pass++;
        repeat (2) tick();
        n_total++; if (out_valid !== 1'b1 || valE !== 64'hFF) $display("FAIL en_freeze valE %h valid %b exp ff 1", valE, out_valid); else n_pass++;
        n_total++; if (cc !== 3'b000 || op_count !== 16'd5) $display("FAIL en_freeze cc %b cnt %0d exp 000 5", cc, op_count); else n_pass++;
        enable = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL en_resume_in_ready got %b exp 1", in_ready); else n_pass++;
        tick();
        n_total++; if (valE !== 64'd5 || op_count !== 16'd6) $display("FAIL en_resume valE %h cnt %0d exp 5 6", valE, op_count); else n_pass++;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            enable    = ($urandom_range(0, 9) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            set_cc    = $urandom_range(0, 1);
            ifun      = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            for (int k = 0; k < 2; k++) begin
                logic [63:0] v;
                case ($urandom_range(0, 7))
                    0: v = 64'h7FFF_FFFF_FFFF_FFFF;
                    1: v = 64'h8000_0000_0000_0000;
                    2: v = '1;
                    3: v = '0;
                    default: v = {$urandom, $urandom};
                endcase
                if (k == 0) valA = v; else valB = v;
            end
            if ($urandom_range(0, 9) == 0) valB = valA;
            #1;
            n_total++; if (in_ready !== (enable && (!m_valid || out_ready))) $display("FAIL rnd_in_ready[%0d] got %b", i, in_ready); else n_pass++;
            tick();
            n_total++;
            if (out_valid !== m_valid || valE !== m_vale || cc !== m_cc || err !== m_err || op_count !== 16'(m_cnt))
                $display("FAIL rnd_state[%0d] got v%b %h cc%b e%b n%0d exp v%b %h cc%b e%b n%0d",
                         i, out_valid, valE, cc, err, op_count, m_valid, m_vale, m_cc, m_err, m_cnt);
            else n_pass++;
        end
        in_valid = 1'b0; enable = 1'b1; out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; out_ready = 1'b0; ifun = 4'd0; valA = 64'd9; valB = 64'd9; set_cc = 1'b1;
        tick();
        in_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        n_total++; if (out_valid !== 1'b0 || valE !== 64'd0) $display("FAIL midrst valid %b valE %h exp 0 0", out_valid, valE); else n_pass++;
        n_total++; if (cc !== 3'b100 || err !== 1'b0 || op_count !== 16'd0) $display("FAIL midrst cc %b err %b cnt %0d exp 100 0 0", cc, err, op_count); else n_pass++;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL midrst_after got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_width8();
        @(negedge clk);
        s_enable = 1'b1; s_out_ready = 1'b1; s_in_valid = 1'b1; s_set_cc = 1'b1;
        s_ifun = 4'd0; s_valA = 8'h80; s_valB = 8'h80;
        @(posedge clk); #1;
        n_total++; if (s_valE !== 8'h00 || s_out_valid !== 1'b1) $display("FAIL w8_add valE %h valid %b exp 00 1", s_valE, s_out_valid); else n_pass++;
        n_total++; if (s_cc !== 3'b101) $display("FAIL w8_add_cc got %b exp 101", s_cc); else n_pass++;
    endtask

    task automatic test_illegal_counter();
        s_ifun = 4'd7; s_valA = 8'h12; s_valB = 8'h34; s_set_cc = 1'b1;
        @(posedge clk); #1;
        n_total++; if (s_valE !== 8'h00 || s_out_valid !== 1'b1) $display("FAIL ill_valE got %h valid %b exp 00 1", s_valE, s_out_valid); else n_pass++;
        n_total++; if (s_cc !== 3'b101) $display("FAIL ill_cc got %b exp 101", s_cc); else n_pass++;
        n_total++; if (s_err !== 1'b1) $display("FAIL ill_err got %b exp 1", s_err); else n_pass++;
        n_total++; if (s_op_count !== 2'd2) $display("FAIL ill_count got %0d exp 2", s_op_count); else n_pass++;
        s_ifun = 4'd3; s_valA = 8'h0F; s_valB = 8'h01; s_set_cc = 1'b0;
        @(posedge clk); #1;
        n_total++; if (s_op_count !== 2'd3 || s_valE !== 8'h0E) $display("FAIL sat_3 cnt %0d valE %h exp 3 0e", s_op_count, s_valE); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (s_op_count !== 2'd3) $display("FAIL sat_hold got %0d exp 3", s_op_count); else n_pass++;
        n_total++; if (s_err !== 1'b1 || s_cc !== 3'b101) $display("FAIL ill_sticky err %b cc %b exp 1 101", s_err, s_cc); else n_pass++;
        s_in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_xor();
        test_overflow();
        test_backpressure();
        test_width8();
        test_illegal_counter();
        test_back_to_back();
        test_enable();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
